// File: rtl/encap_packet.sv
// Splits one captured routing header plus partial-bitstream payload into a fixed run of Aurora TX beats.
// Each beat carries the header in its low bits and the next payload slice above it; the last slice is zero-padded.
module encap_packet #(
  parameter int DATA_DFX_WIDTH    = 1034,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int HEADER_WIDTH      = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [HEADER_WIDTH-1:0]      header_pkt_in,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_in,
  output logic [AURORA_DATA_WIDTH-1:0] tx_tdata,
  output logic                         tx_tvalid,
  input  logic                         tx_tready,
  output logic                         tx_tlast,
  output logic                         encap_done,
  output logic [15:0]                  pkt_cnt
);

  localparam int SLICE  = AURORA_DATA_WIDTH - HEADER_WIDTH;
  localparam int NBEATS = (DATA_DFX_WIDTH + SLICE - 1) / SLICE;
  localparam int PAD_W  = NBEATS * SLICE;
  localparam logic [4:0] LAST_BEAT = 5'(NBEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state;
  logic [4:0]                frame_cnt;
  logic [HEADER_WIDTH-1:0]   hdr_q;
  logic [DATA_DFX_WIDTH-1:0] data_q;
  logic [PAD_W-1:0]          data_pad;
  logic [SLICE-1:0]          slice;

  // Zero-extending the payload makes the short final slice come out zero-padded at the top.
  assign data_pad = PAD_W'(data_q);
  assign slice    = data_pad[int'(frame_cnt)*SLICE +: SLICE];

  // Outputs decode only from registers, so tx_tready never reaches tx_tvalid combinationally.
  assign tx_tdata = tx_tvalid ? {slice, hdr_q} : '0;
  assign tx_tlast = tx_tvalid && (frame_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      hdr_q      <= '0;
      data_q     <= '0;
      in_ready   <= 1'b0;
      tx_tvalid  <= 1'b0;
      encap_done <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      encap_done <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            hdr_q     <= header_pkt_in;
            data_q    <= data_dfx_in;
            frame_cnt <= '0;
            in_ready  <= 1'b0;
            tx_tvalid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (tx_tready) begin
            if (frame_cnt == LAST_BEAT) begin
              frame_cnt  <= '0;
              tx_tvalid  <= 1'b0;
              in_ready   <= 1'b1;
              encap_done <= 1'b1;
              pkt_cnt    <= pkt_cnt + 16'd1;
              state      <= IDLE;
            end else begin
              frame_cnt <= frame_cnt + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encap_packet.sv
// Directed bench for encap_packet: beat slicing, backpressure, busy handling, reset abort and counter wrap.
module tb_encap_packet;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [8:0]    header;
  logic [1033:0] payload;
  logic [63:0]   tx_tdata;
  logic          tx_tvalid;
  logic          tx_tready;
  logic          tx_tlast;
  logic          encap_done;
  logic [15:0]   pkt_cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [1033:0] p3;
  logic [1033:0] pr;

  always #5 clk = ~clk;

  encap_packet dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .header_pkt_in (header),
    .data_dfx_in   (payload),
    .tx_tdata      (tx_tdata),
    .tx_tvalid     (tx_tvalid),
    .tx_tready     (tx_tready),
    .tx_tlast      (tx_tlast),
    .encap_done    (encap_done),
    .pkt_cnt       (pkt_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat k = 55-bit payload slice above the 9-bit header, payload zero-extended to 19*55 bits.
  function automatic logic [63:0] exp_beat(input logic [1033:0] d, input logic [8:0] h, input int k);
    logic [1044:0] p;
    p = {11'b0, d};
    return {p[k*55 +: 55], h};
  endfunction

  // Called just after a negedge; returns at the negedge that should show encap_done.
  task automatic run_pkt(input logic [8:0] h, input logic [1033:0] d, input bit stall, input bit hold,
                         input logic [15:0] exp_cnt, input bit hc_en,
                         input logic [63:0] hc_first, input logic [63:0] hc_last);
    int n   = 0;
    int k   = 0;
    int cyc = 0;
    header    = h;
    payload   = d;
    in_valid  = 1'b1;
    tx_tready = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(n < 50), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    @(negedge clk);
    check("first_valid", 64'(tx_tvalid), 64'd1);
    check("done_low", 64'(encap_done), 64'd0);
    while (k < 19 && cyc < 200) begin
      if (hold) begin
        check("busy_ready", 64'(in_ready), 64'd0);
        payload = ~payload;
        header  = header ^ 9'h0F3;
      end
      tx_tready = stall ? (cyc % 3 == 0) : 1'b1;
      check("valid", 64'(tx_tvalid), 64'd1);
      check("beat", tx_tdata, exp_beat(d, h, k));
      check("last", 64'(tx_tlast), 64'(k == 18));
      if (hc_en && k == 0)  check("beat_first_hc", tx_tdata, hc_first);
      if (hc_en && k == 18) check("beat_last_hc", tx_tdata, hc_last);
      if (tx_tready) k++;
      @(negedge clk);
      cyc++;
    end
    check("beat_count", 64'(k), 64'd19);
    check("done_pulse", 64'(encap_done), 64'd1);
    check("valid_drop", 64'(tx_tvalid), 64'd0);
    check("last_drop", 64'(tx_tlast), 64'd0);
    check("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
    check("ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    tx_tready = 1'b0;
    header    = 9'h1FF;
    payload   = '1;
    for (int i = 0; i < 1034; i++) p3[i] = (i % 3 == 0);
    for (int i = 0; i < 1034; i++) pr[i] = 1'($urandom_range(0, 1));

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(tx_tvalid), 64'd0);
    check("rst_last", 64'(tx_tlast), 64'd0);
    check("rst_data", tx_tdata, 64'd0);
    check("rst_done", 64'(encap_done), 64'd0);
    check("rst_cnt", 64'(pkt_cnt), 64'd0);

    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);
    tx_tready = 1'b1;
    @(negedge clk);
    check("idle_ready_noeffect", 64'(tx_tvalid), 64'd0);
    check("idle_cnt", 64'(pkt_cnt), 64'd0);

    run_pkt(9'h1A5, p3, 1'b0, 1'b0, 16'd1, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(encap_done), 64'd0);

    run_pkt(9'h0C3, pr, 1'b1, 1'b0, 16'd2, 1'b0, 64'd0, 64'd0);

    run_pkt(9'h155, p3 ^ pr, 1'b0, 1'b1, 16'd3, 1'b0, 64'd0, 64'd0);
    run_pkt(9'h02A, ~p3, 1'b0, 1'b0, 16'd4, 1'b0, 64'd0, 64'd0);

    run_pkt(9'h1FF, '1, 1'b0, 1'b0, 16'd5, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h001F_FFFF_FFFF_FFFF);

    // Abort mid-packet: beat 7 transfers, then reset with in_valid held high.
    header   = 9'h0AA;
    payload  = pr;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("pre_rst_beat", tx_tdata, exp_beat(pr, 9'h0AA, k));
    end
    @(negedge clk);
    check("pre_rst_beat8", tx_tdata, exp_beat(pr, 9'h0AA, 8));
    rst      = 1'b1;
    in_valid = 1'b1;
    header   = 9'h111;
    @(negedge clk);
    check("abort_valid", 64'(tx_tvalid), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd0);
    check("abort_cnt", 64'(pkt_cnt), 64'd0);
    check("abort_data", tx_tdata, 64'd0);
    @(negedge clk);
    check("abort_done", 64'(encap_done), 64'd0);
    check("rst_in_valid_ignored", 64'(tx_tvalid), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_abort", 64'(in_ready), 64'd1);
    check("no_done_after_abort", 64'(encap_done), 64'd0);
    run_pkt(9'h033, p3, 1'b0, 1'b0, 16'd1, 1'b0, 64'd0, 64'd0);

    @(negedge clk);
    force dut.pkt_cnt = 16'hFFFF;
    #1;
    release dut.pkt_cnt;
    @(negedge clk);
    check("preload_cnt", 64'(pkt_cnt), 64'hFFFF);
    run_pkt(9'h0F0, pr, 1'b0, 1'b0, 16'h0000, 1'b0, 64'd0, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/encap_packet.md
ENCAP_PACKET -- requirements
Module: encap_packet

Interface
REQ-001 The module SHALL have parameter DATA_DFX_WIDTH, default 1034, meaning the width of the partial-bitstream payload word (1024 data + 10 address).
REQ-002 The module SHALL have parameter AURORA_DATA_WIDTH, default 64, meaning the Aurora TX beat width.
REQ-003 The module SHALL have parameter HEADER_WIDTH, default 9, meaning the per-beat routing header width.
REQ-004 The module SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit, meaning the reset, which is synchronous and active-high.
REQ-006 The module SHALL have port in_valid, input, 1 bit, meaning a packet is offered.
REQ-007 The module SHALL have port in_ready, output, 1 bit, meaning the block can accept a packet.
REQ-008 The module SHALL have port header_pkt_in, input, HEADER_WIDTH bits, meaning the routing header.
REQ-009 The module SHALL have port data_dfx_in, input, DATA_DFX_WIDTH bits, meaning the payload.
REQ-010 The module SHALL have port tx_tdata, output, AURORA_DATA_WIDTH bits, meaning the outgoing beat.
REQ-011 The module SHALL have port tx_tvalid, output, 1 bit, meaning tx_tdata is valid.
REQ-012 The module SHALL have port tx_tready, input, 1 bit, meaning the sink accepts the beat.
REQ-013 The module SHALL have port tx_tlast, output, 1 bit, meaning this is the final beat of a packet.
REQ-014 The module SHALL have port encap_done, output, 1 bit, meaning a one-cycle pulse after the last beat is accepted.
REQ-015 The module SHALL have port pkt_cnt, output, 16 bits, meaning a count of packets fully sent.

Function
REQ-016 The block SHALL implement an FSM with two states: IDLE and SEND.
REQ-017 In IDLE, the block SHALL drive in_ready=1 and tx_tvalid=0.
REQ-018 On in_valid&&in_ready, the block SHALL register header_pkt_in and data_dfx_in, clear frame_cnt (5 bits) to 0 and enter SEND.
REQ-019 The first beat SHALL present tx_tvalid=1 on the cycle after acceptance (latency 1).
REQ-020 In SEND, the block SHALL drive in_ready=0 and ignore in_valid and its inputs; the captured values SHALL NOT change.
REQ-021 Each packet SHALL be exactly 19 beats, frame_cnt 0..18.
REQ-022 For beats k=0..17, tx_tdata[63:9] SHALL equal payload[k*55 +: 55].
REQ-023 For beat 18, tx_tdata[63:53] SHALL be 0 and tx_tdata[52:9] SHALL equal payload[1033:990].
REQ-024 On every beat, tx_tdata[8:0] SHALL equal the captured header.
REQ-025 tx_tlast SHALL be 1 only while frame_cnt==18 and tx_tvalid=1.
REQ-026 A beat SHALL transfer only when tx_tvalid&&tx_tready.
REQ-027 While tx_tvalid=1 and tx_tready=0, tx_tdata, tx_tlast and frame_cnt SHALL hold stable.
REQ-028 tx_tvalid SHALL NOT deassert before the beat transfers.
REQ-029 On a transfer with frame_cnt<18, frame_cnt SHALL increment by 1.
REQ-030 On a transfer with frame_cnt==18, the next cycle SHALL have: state IDLE, tx_tvalid=0, encap_done=1 for exactly one cycle, and pkt_cnt incremented by 1.
REQ-031 pkt_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-032 With tx_tready held at 1, a packet SHALL occupy 19 transfer cycles, giving a minimum acceptance-to-acceptance spacing of 20 cycles.
REQ-033 All outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from tx_tready to tx_tvalid.
REQ-034 tx_tready asserted while tx_tvalid=0 SHALL have no effect.

Reset
REQ-035 While rst=1 at a clock edge, the block SHALL set state=IDLE, frame_cnt=0, tx_tvalid=0, tx_tlast=0, tx_tdata=0, encap_done=0, pkt_cnt=0, and clear the captured header and payload to 0.
REQ-036 in_ready SHALL be 0 during reset and 1 from the first cycle after rst deasserts.
REQ-037 Reset asserted mid-packet SHALL abort the packet: no further beats, no encap_done, and pkt_cnt unchanged from 0 (reset value).
REQ-038 in_valid asserted in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-039 Scenario: header=0x1A5, payload with bit i set to (i mod 3==0), tx_tready=1 -> 19 beats on consecutive cycles; beat 0 [63:9]=payload[54:0]; beat 18 [63:53]=0; tx_tlast only on beat 18; encap_done pulses one cycle later; pkt_cnt=1.
REQ-040 Scenario: tx_tready toggling 1,0,0,1,... through a packet -> tx_tdata stable during every stall; the 19 beats match REQ-022 to REQ-024 in order; no beat is dropped or duplicated.
REQ-041 Scenario: in_valid held at 1 with changing data throughout SEND -> in_ready=0 and the output stays from the first captured packet; the second packet is accepted on the cycle after encap_done.
REQ-042 Scenario: rst=1 after beat 7 is accepted -> next cycle tx_tvalid=0, in_ready=0, pkt_cnt=0; after release, a new packet is sent from beat 0.
REQ-043 Scenario: pkt_cnt preloaded by sending 65535 packets (or forced), then one more packet -> pkt_cnt=0x0000.
REQ-044 Scenario: payload all ones, header=0x1FF -> beats 0..17 are 0xFFFFFFFFFFFFFFFF; beat 18 is 0x001FFFFFFFFFFFFF.
